// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices and signal levels.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned PcStage  = 0;
    localparam int unsigned IfStage  = 1;
    localparam int unsigned IdStage  = 2;
    localparam int unsigned ExStage  = 3;
    localparam int unsigned MemStage = 4;
    localparam int unsigned WbStage  = 5;

    localparam logic RstActive = 1'b0;
    localparam logic Stop      = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned NSTAGE = 6,
    parameter int unsigned CNT_W  = 32
);
    logic              rdy;
    logic [NSTAGE-1:0] stall_req;
    logic [NSTAGE-1:0] flush_req;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              stall_timeout;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output rdy, stall_req, flush_req,
        input  stall, flush, stall_timeout, stall_cycles
    );

    modport slave (
        input  rdy, stall_req, flush_req,
        output stall, flush, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/hi_prio_enc.sv
// Highest-set-bit encoder; bits below LO never count as requests.
module hi_prio_enc #(
    parameter int unsigned W  = 6,
    parameter int unsigned LO = 0,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          vld,
    output logic [IW-1:0] idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (req[i] && (i >= int'(LO))) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Merges stall/flush requests into per-stage masks, defers flushes behind older stalls,
// and keeps a sticky stall watchdog plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE  = 6,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned IW  = $clog2(NSTAGE);
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

    logic          s_vld, f_vld, fe_vld;
    logic [IW-1:0] s_idx, f_idx, fe_idx;

    logic              pend_vld_q, pend_vld_d;
    logic [IW-1:0]     pend_idx_q, pend_idx_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NSTAGE-1:0] s_mask, f_mask, stall, flush;
    logic              active;

    hi_prio_enc #(.W(NSTAGE), .LO(IfStage)) u_stall_enc (
        .req (bus.stall_req),
        .vld (s_vld),
        .idx (s_idx)
    );

    hi_prio_enc #(.W(NSTAGE), .LO(IdStage)) u_flush_enc (
        .req (bus.flush_req),
        .vld (f_vld),
        .idx (f_idx)
    );

    // Deeper flush wins: its bubble mask covers the shallower one.
    always_comb begin
        fe_vld = f_vld | pend_vld_q;
        fe_idx = f_idx;
        if (pend_vld_q && (!f_vld || (pend_idx_q > f_idx))) begin
            fe_idx = pend_idx_q;
        end
        s_mask = '0;
        f_mask = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            s_mask[i] = s_vld && (IW'(i) <= s_idx);
        end
        for (int i = 1; i < NSTAGE; i++) begin
            f_mask[i] = (IW'(i) < fe_idx);
        end
    end

    always_comb begin
        stall      = '0;
        flush      = '0;
        active     = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        if (rst == RstActive) begin
            pend_vld_d = 1'b0;
        end else if (!bus.rdy) begin
            stall = {NSTAGE{Stop}};
            if (fe_vld) begin
                pend_vld_d = 1'b1;
                pend_idx_d = fe_idx;
            end
        end else begin
            active = 1'b1;
            if (fe_vld && (!s_vld || (s_idx < fe_idx))) begin
                flush      = f_mask;
                pend_vld_d = 1'b0;
            end else if (fe_vld) begin
                stall      = s_mask;
                pend_vld_d = 1'b1;
                pend_idx_d = fe_idx;
            end else begin
                stall = s_mask;
            end
        end

        wd_d  = wd_q;
        cnt_d = cnt_q;
        if (active) begin
            if (|stall) begin
                if (wd_q != WdMax) wd_d = wd_q + 1'b1;
                if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
            end else begin
                wd_d = '0;
            end
        end
        to_d = to_q | (wd_d == WdMax);
    end

    always_ff @(posedge clk) begin
        if (rst == RstActive) begin
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            wd_q       <= '0;
            to_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            wd_q       <= wd_d;
            to_q       <= to_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.stall_timeout = to_q;
    assign bus.stall_cycles  = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT shortened to 4.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NSTAGE(6), .CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.NSTAGE(6), .TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_in(input logic r, input logic [5:0] s, input logic [5:0] f);
        bus.rdy       = r;
        bus.stall_req = s;
        bus.flush_req = f;
        #2;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_masks(input string name, input logic [5:0] es, input logic [5:0] ef);
        total++;
        if (bus.stall !== es) begin
            bad++;
            $display("FAIL %s stall: got %b want %b", name, bus.stall, es);
        end
        total++;
        if (bus.flush !== ef) begin
            bad++;
            $display("FAIL %s flush: got %b want %b", name, bus.flush, ef);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1'b1, 6'b010000, 6'b001000);
        chk_masks("reset_cycle", 6'b000000, 6'b000000);
        next_cyc();
        rst = 1'b1;
        set_in(1'b1, 6'b000000, 6'b000000);
        total++;
        if (bus.stall_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_timeout: got %b want 0", bus.stall_timeout);
        end
        total++;
        if (bus.stall_cycles !== 32'd0) begin
            bad++; $display("FAIL reset_cycles: got %0d want 0", bus.stall_cycles);
        end
        chk_masks("after_reset_idle", 6'b000000, 6'b000000);
        next_cyc();
    endtask

    task automatic test_single_stall();
        set_in(1'b1, 6'b000100, 6'b000000);
        chk_masks("stall_id", 6'b000111, 6'b000000);
        next_cyc();
        set_in(1'b1, 6'b010010, 6'b000000);
        chk_masks("stall_mem_if", 6'b011111, 6'b000000);
        next_cyc();
        set_in(1'b1, 6'b000001, 6'b000000);
        chk_masks("stall_bit0_ignored", 6'b000000, 6'b000000);
        next_cyc();
    endtask

    task automatic test_immediate_flush();
        set_in(1'b1, 6'b000000, 6'b001000);
        chk_masks("flush_ex", 6'b000000, 6'b000110);
        next_cyc();
        set_in(1'b1, 6'b000100, 6'b010000);
        chk_masks("flush_mem_younger_stall", 6'b000000, 6'b001110);
        next_cyc();
        set_in(1'b1, 6'b000000, 6'b000011);
        chk_masks("flush_low_bits_ignored", 6'b000000, 6'b000000);
        next_cyc();
        set_in(1'b1, 6'b000000, 6'b100000);
        chk_masks("flush_wb", 6'b000000, 6'b011110);
        next_cyc();
    endtask

    task automatic test_deferred_flush();
        set_in(1'b1, 6'b010000, 6'b001000);
        chk_masks("defer_c1", 6'b011111, 6'b000000);
        next_cyc();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 6'b010000, 6'b000000);
            chk_masks("defer_hold", 6'b011111, 6'b000000);
            next_cyc();
        end
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("defer_issue", 6'b000000, 6'b000110);
        next_cyc();
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("defer_pulse_end", 6'b000000, 6'b000000);
        next_cyc();
    endtask

    task automatic test_merge();
        set_in(1'b1, 6'b010000, 6'b001000);
        chk_masks("merge_capture", 6'b011111, 6'b000000);
        next_cyc();
        set_in(1'b1, 6'b010000, 6'b010000);
        chk_masks("merge_equal_defers", 6'b011111, 6'b000000);
        next_cyc();
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("merge_issue", 6'b000000, 6'b001110);
        next_cyc();
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("merge_once", 6'b000000, 6'b000000);
        next_cyc();
    endtask

    // 7 stalled cycles have accumulated since reset (2 + 3 + 2).
    task automatic test_freeze();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 6'b000010, (i == 4) ? 6'b001000 : 6'b000000);
            chk_masks("freeze", 6'b111111, 6'b000000);
            total++;
            if (bus.stall_cycles !== 32'd7) begin
                bad++; $display("FAIL freeze_cycles: got %0d want 7", bus.stall_cycles);
            end
            next_cyc();
        end
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("freeze_captured_flush", 6'b000000, 6'b000110);
        total++;
        if (bus.stall_timeout !== 1'b0) begin
            bad++; $display("FAIL freeze_no_timeout: got %b want 0", bus.stall_timeout);
        end
        next_cyc();
        set_in(1'b1, 6'b000000, 6'b000000);
        total++;
        if (bus.stall_cycles !== 32'd7) begin
            bad++; $display("FAIL freeze_cycles_after: got %0d want 7", bus.stall_cycles);
        end
        next_cyc();
    endtask

    task automatic test_watchdog();
        rst = 1'b0;
        set_in(1'b1, 6'b000000, 6'b000000);
        next_cyc();
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            set_in(1'b1, 6'b000100, 6'b000000);
            total++;
            if (bus.stall_timeout !== ((k >= 5) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL wd_timeout c%0d: got %b want %b", k, bus.stall_timeout, k >= 5);
            end
            total++;
            if (bus.stall_cycles !== 32'(k - 1)) begin
                bad++; $display("FAIL wd_cycles c%0d: got %0d want %0d", k, bus.stall_cycles, k - 1);
            end
            next_cyc();
        end
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("wd_release", 6'b000000, 6'b000000);
        total++;
        if (bus.stall_timeout !== 1'b1) begin
            bad++; $display("FAIL wd_sticky: got %b want 1", bus.stall_timeout);
        end
        total++;
        if (bus.stall_cycles !== 32'd6) begin
            bad++; $display("FAIL wd_cycles_total: got %0d want 6", bus.stall_cycles);
        end
        next_cyc();
        rst = 1'b0;
        set_in(1'b1, 6'b000100, 6'b000000);
        chk_masks("wd_reset_cycle", 6'b000000, 6'b000000);
        next_cyc();
        rst = 1'b1;
        set_in(1'b1, 6'b000000, 6'b000000);
        total++;
        if (bus.stall_timeout !== 1'b0) begin
            bad++; $display("FAIL wd_reset_timeout: got %b want 0", bus.stall_timeout);
        end
        total++;
        if (bus.stall_cycles !== 32'd0) begin
            bad++; $display("FAIL wd_reset_cycles: got %0d want 0", bus.stall_cycles);
        end
        next_cyc();
    endtask

    task automatic test_reset_mid_deferral();
        set_in(1'b1, 6'b010000, 6'b001000);
        chk_masks("rstdef_capture", 6'b011111, 6'b000000);
        next_cyc();
        rst = 1'b0;
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("rstdef_reset_cycle", 6'b000000, 6'b000000);
        next_cyc();
        rst = 1'b1;
        set_in(1'b1, 6'b000000, 6'b000000);
        chk_masks("rstdef_flush_lost", 6'b000000, 6'b000000);
        next_cyc();
    endtask

    initial begin
        bus.rdy       = 1'b1;
        bus.stall_req = '0;
        bus.flush_req = '0;
        test_reset();
        test_single_stall();
        test_immediate_flush();
        test_deferred_flush();
        test_merge();
        test_freeze();
        test_watchdog();
        test_reset_mid_deferral();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the RISC-V core.
- Merges per-stage stall requests and branch/exception flush requests into per-stage `stall` and `flush` masks.
- Defers a flush while an equal-or-older stage is stalled, then issues it.
- Tracks consecutive-stall cycles with a sticky watchdog and keeps a saturating stall-cycle performance counter.
- Sits beside the pipeline registers; every stage register and the PC register consume its outputs.

## Interface
- `NSTAGE`, 6: pipeline stages including PC. Index 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `TIMEOUT`, 1024: consecutive stalled cycles that raise `stall_timeout`. Must be ≥ 1.
- `CNT_W`, 32: width of `stall_cycles`.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-low (asserted when `rst == 0`).
- `rdy` in 1: global ready; low freezes the whole pipeline.
- `stall_req` in NSTAGE: bit k = stage k requests stall; bit 0 ignored.
- `flush_req` in NSTAGE: bit k = stage k redirects and kills younger stages; bits 0–1 ignored.
- `stall` out NSTAGE: per-stage hold mask, combinational.
- `flush` out NSTAGE: per-stage bubble-insert mask, combinational.
- `stall_timeout` out 1: sticky watchdog flag.
- `stall_cycles` out CNT_W: saturating count of cycles with `stall != 0`.

## Operation
- `S` = highest k ≥ 1 with `stall_req[k]`, or none.
- `F` = highest k ≥ 2 with `flush_req[k]`, or none.
- `P` = pending-flush register (valid bit + index).
- `Fe` = max(`F`, `P`), using only the valid ones.
- Stall mask for index k: bits 0..k set, all others clear (generalises IF→000011, ID→000111, MEM→011111).

Priority, evaluated each cycle:
1. **`rst` low:** `stall = 0`, `flush = 0`. Next state: `P` invalid, watchdog = 0, `stall_timeout = 0`, `stall_cycles = 0`.
2. **`rdy` low:** `stall = all ones`, `flush = 0`. `P` <= `Fe` when valid, otherwise unchanged. Watchdog and `stall_cycles` are frozen.
3. **Fe valid and (S none or S < Fe):** issue the flush.
   - `flush` = bits 1..Fe-1; `stall = 0`, so the PC loads the redirect target. Any younger stall is discarded.
   - `P` <= invalid.
4. **Fe valid and S ≥ Fe:** defer the flush.
   - `stall` = mask(S), `flush = 0`, `P` <= `Fe`.
5. **Otherwise:** `stall` = mask(S) if S exists, else 0; `flush = 0`.

Counters and pending state:
- Watchdog (priority cases 3–5 only): increments while `stall != 0`, clears to 0 when `stall == 0`, and saturates at `TIMEOUT`. Reaching `TIMEOUT` sets `stall_timeout`, which stays set until reset.
- `stall_cycles`: increments in any case 3–5 cycle with `stall != 0`; saturates at all ones.
- Pending merge: a deeper (older) flush supersedes a shallower one. Its mask is a superset, so taking the max is always correct.

## Timing
- `stall` and `flush` are zero-latency, combinational from `stall_req`, `flush_req`, `rdy`, `rst` and `P`.
- A deferred flush is issued in the first cycle after capture where S < `P`. Minimum deferral is 1 cycle.
- A flush is a one-cycle pulse per issue. A held `flush_req` re-issues every cycle, so the requester must drop it once the flush has been accepted.
- `stall_timeout` rises the cycle after the watchdog reaches `TIMEOUT`; `stall_cycles` is updated on the clock edge.
- Reset mid-deferral: the pending flush is lost, and outputs are 0 during every reset cycle.
- Simultaneous new `F` and older `P`: merged by max in the same cycle.

## Structure
- Constants go in `config.v`:
  - `Stop`
  - stage index defines `PcStage`..`WbStage`
  - active-low reset level `RstActive` = 1'b0
- Sub-module `hi_prio_enc` (NSTAGE-wide, outputs valid + index):
  - instantiated for `stall_req` and for `flush_req`;
  - mask generation and max-merge stay in the top module.

## Test plan
- **Single stall:** `stall_req = 000100` → `stall = 000111`, `flush = 0`. Then `stall_req = 010010` → `stall = 011111`.
- **Immediate flush:** EX branch, `flush_req = 001000`, no stall → `flush = 000110` and `stall = 0` in the same cycle.
- **Deferred flush:** `flush_req = 001000` with `stall_req = 010000` held 3 cycles. Expect `stall = 011111` and `flush = 0` for 3 cycles, then `flush = 000110` on the cycle `stall_req` drops. `flush` must be 0 the following cycle.
- **Merge:** pending EX flush (`P` = 3) plus new `flush_req = 010000` while MEM-stalled. Once the stall releases, `flush = 001110` is issued once.
- **Freeze:** `rdy = 0` with `stall_req = 000010` → `stall = 111111`. `stall_cycles` is unchanged across 5 such cycles.
- **Watchdog:** `TIMEOUT = 4`, `stall_req = 000100` held 6 cycles → `stall_timeout = 1` from cycle 5. It stays set after release, and `stall_cycles = 6`. Pulling `rst` low for 1 cycle clears all three.
